// File: rtl/wts_adsr_envelope_multi_if.sv
// Bundle between the channel register file and the multi-channel ADSR envelope block.
// Rates, sustain levels and key pulses are packed per channel, channel k at index k.
interface wts_adsr_envelope_multi_if #(
  parameter int CH     = 5,
  parameter int ENV_W  = 9,
  parameter int RATE_W = 16
);
  logic                          active_i;
  logic [CH-1:0]                 key_on_i;
  logic [CH-1:0]                 key_release_i;
  logic [CH-1:0]                 key_off_i;
  logic [CH-1:0][RATE_W-1:0]     reg_ar_i;
  logic [CH-1:0][RATE_W-1:0]     reg_dr_i;
  logic [CH-1:0][RATE_W-1:0]     reg_sr_i;
  logic [CH-1:0][RATE_W-1:0]     reg_rr_i;
  logic [CH-1:0][ENV_W-2:0]      reg_sl_i;
  logic [CH-1:0][ENV_W-1:0]      envelope_o;
  logic                          busy_o;
  logic                          overrun_o;

  modport master (
    output active_i, key_on_i, key_release_i, key_off_i,
    output reg_ar_i, reg_dr_i, reg_sr_i, reg_rr_i, reg_sl_i,
    input  envelope_o, busy_o, overrun_o
  );

  modport slave (
    input  active_i, key_on_i, key_release_i, key_off_i,
    input  reg_ar_i, reg_dr_i, reg_sr_i, reg_rr_i, reg_sl_i,
    output envelope_o, busy_o, overrun_o
  );
endinterface

// File: rtl/wts_adsr_envelope_multi.sv
// Time-multiplexed ADSR envelope generator: one shared update datapath sweeps all
// channels, one channel per clk, each time an `active` pulse arrives.
module wts_adsr_envelope_multi #(
  parameter int CH     = 5,
  parameter int ENV_W  = 9,
  parameter int RATE_W = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  wts_adsr_envelope_multi_if.slave      bus
);

  localparam int                IDX_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [ENV_W-1:0]  ENV_MAX = {1'b1, {(ENV_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } env_state_e;

  // per-channel storage
  env_state_e                state_q [CH];
  env_state_e                state_d [CH];
  logic [CH-1:0][ENV_W-1:0]  env_q,  env_d;
  logic [CH-1:0][RATE_W-1:0] cnt_q,  cnt_d;
  logic [CH-1:0]             pon_q,  pon_d;
  logic [CH-1:0]             prel_q, prel_d;
  logic [CH-1:0]             poff_q, poff_d;

  // sweep control
  logic                      busy_q, busy_d;
  logic                      ovr_q,  ovr_d;
  logic [IDX_W-1:0]          idx_q,  idx_d;

  // shared slot datapath
  env_state_e                cur_st, nxt_st;
  logic [ENV_W-1:0]          cur_env, nxt_env, env_dn, sl;
  logic [RATE_W-1:0]         cur_cnt, nxt_cnt, rate, ar, dr, sr, rr;
  logic                      ev_on, ev_rel, ev_off, step;

  always_comb begin : slot_mux
    cur_st  = state_q[idx_q];
    cur_env = env_q[idx_q];
    cur_cnt = cnt_q[idx_q];
    ar      = bus.reg_ar_i[idx_q];
    dr      = bus.reg_dr_i[idx_q];
    sr      = bus.reg_sr_i[idx_q];
    rr      = bus.reg_rr_i[idx_q];
    sl      = {1'b0, bus.reg_sl_i[idx_q]};
    // a pulse landing on the slot edge is folded in here and its pend bit is dropped
    ev_off  = poff_q[idx_q] | bus.key_off_i[idx_q];
    ev_on   = pon_q[idx_q]  | bus.key_on_i[idx_q];
    ev_rel  = prel_q[idx_q] | bus.key_release_i[idx_q];
    env_dn  = (cur_env == '0) ? '0 : cur_env - ENV_W'(1);
    unique case (cur_st)
      S_ATTACK:  rate = ar;
      S_DECAY:   rate = dr;
      S_SUSTAIN: rate = sr;
      S_RELEASE: rate = rr;
      default:   rate = '0;
    endcase
  end

  always_comb begin : slot_update
    nxt_st  = cur_st;
    nxt_env = cur_env;
    nxt_cnt = cur_cnt;
    step    = 1'b0;
    if (ev_off) begin
      nxt_st  = S_IDLE;
      nxt_env = '0;
      nxt_cnt = '0;
    end else if (ev_on) begin
      nxt_cnt = '0;
      if (ar == '0) begin
        nxt_env = ENV_MAX;
        nxt_st  = S_DECAY;
      end else begin
        nxt_st  = S_ATTACK;
      end
    end else if (ev_rel && cur_st != S_IDLE && cur_st != S_RELEASE) begin
      nxt_st  = S_RELEASE;
      nxt_cnt = '0;
    end else if (cur_st == S_DECAY && (dr == '0 || cur_env <= sl)) begin
      nxt_env = (dr == '0) ? sl : cur_env;
      nxt_st  = S_SUSTAIN;
      nxt_cnt = '0;
    end else if (rate != '0) begin
      if (({1'b0, cur_cnt} + (RATE_W+1)'(1)) >= {1'b0, rate}) begin
        nxt_cnt = '0;
        step    = 1'b1;
      end else begin
        nxt_cnt = cur_cnt + RATE_W'(1);
      end
    end

    if (step) begin
      unique case (cur_st)
        S_ATTACK: begin
          if (cur_env >= ENV_MAX - ENV_W'(1)) begin
            nxt_env = ENV_MAX;
            nxt_st  = S_DECAY;
          end else begin
            nxt_env = cur_env + ENV_W'(1);
          end
        end
        S_DECAY: begin
          nxt_env = env_dn;
          if (env_dn <= sl) nxt_st = S_SUSTAIN;
        end
        S_SUSTAIN: nxt_env = env_dn;
        S_RELEASE: begin
          nxt_env = env_dn;
          if (env_dn == '0) nxt_st = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    env_d   = env_q;
    cnt_d   = cnt_q;
    pon_d   = pon_q  | bus.key_on_i;
    prel_d  = prel_q | bus.key_release_i;
    poff_d  = poff_q | bus.key_off_i;
    busy_d  = busy_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    if (busy_q) begin
      state_d[idx_q] = nxt_st;
      env_d[idx_q]   = nxt_env;
      cnt_d[idx_q]   = nxt_cnt;
      pon_d[idx_q]   = 1'b0;
      prel_d[idx_q]  = 1'b0;
      poff_d[idx_q]  = 1'b0;
      if (idx_q == LAST) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
      end
      if (bus.active_i) ovr_d = 1'b1;
    end else if (bus.active_i) begin
      busy_d = 1'b1;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < CH; k++) state_q[k] <= S_IDLE;
      env_q  <= '0;
      cnt_q  <= '0;
      pon_q  <= '0;
      prel_q <= '0;
      poff_q <= '0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      cnt_q   <= cnt_d;
      pon_q   <= pon_d;
      prel_q  <= prel_d;
      poff_q  <= poff_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.envelope_o = env_q;
  assign bus.busy_o     = busy_q;
  assign bus.overrun_o  = ovr_q;

endmodule

// File: tb/tb_wts_adsr_envelope_multi.sv
// Directed bench for the multi-channel ADSR envelope: four channels, one sweep every 6 clk.
module tb_wts_adsr_envelope_multi;
  localparam int CH = 4, ENV_W = 9, RATE_W = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  wts_adsr_envelope_multi_if #(.CH(CH), .ENV_W(ENV_W), .RATE_W(RATE_W)) ifc ();

  wts_adsr_envelope_multi #(.CH(CH), .ENV_W(ENV_W), .RATE_W(RATE_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (ifc)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int env(input int ch);
    return int'(ifc.envelope_o[ch]);
  endfunction

  // one active pulse followed by five quiet clocks
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ifc.active_i = 1'b1;
      @(negedge clk) ifc.active_i = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic key(input bit on, input bit rel, input bit off, input int ch);
    @(negedge clk);
    ifc.key_on_i[ch]      = on;
    ifc.key_release_i[ch] = rel;
    ifc.key_off_i[ch]     = off;
    @(negedge clk);
    ifc.key_on_i      = '0;
    ifc.key_release_i = '0;
    ifc.key_off_i     = '0;
  endtask

  initial begin
    reset             = 1'b1;
    ifc.active_i      = 1'b0;
    ifc.key_on_i      = '0;
    ifc.key_release_i = '0;
    ifc.key_off_i     = '0;
    ifc.reg_ar_i      = '0;
    ifc.reg_dr_i      = '0;
    ifc.reg_sr_i      = '0;
    ifc.reg_rr_i      = '0;
    ifc.reg_sl_i      = '0;
    ifc.reg_ar_i[1]   = 16'd1;
    ifc.reg_ar_i[2]   = 16'd2;
    ifc.reg_dr_i[2]   = 16'd3;
    ifc.reg_sl_i[2]   = 8'd200;
    ifc.reg_sr_i[2]   = 16'd100;
    ifc.reg_rr_i[2]   = 16'd4;
    ifc.reg_ar_i[3]   = 16'd1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_env0", env(0), 0);
    chk("rst_env3", env(3), 0);
    chk("rst_busy", int'(ifc.busy_o), 0);
    chk("rst_ovr",  int'(ifc.overrun_o), 0);

    // busy rises on the active edge and falls after the last channel slot
    @(negedge clk) ifc.active_i = 1'b1;
    @(negedge clk) ifc.active_i = 1'b0;
    chk("busy_hi", int'(ifc.busy_o), 1);
    repeat (4) @(negedge clk);
    chk("busy_lo", int'(ifc.busy_o), 0);
    sweep(49);
    chk("idle_env0", env(0), 0);
    chk("idle_env2", env(2), 0);
    chk("idle_ovr",  int'(ifc.overrun_o), 0);

    // ch0: AR=0 jumps straight to MAX; release with RR=0 holds
    key(1, 0, 0, 0);
    chk("latched_no_change", env(0), 0);
    sweep(1);
    chk("ar0_env0", env(0), 256);
    chk("ar0_env1", env(1), 0);
    chk("ar0_env2", env(2), 0);
    chk("ar0_env3", env(3), 0);
    key(0, 1, 0, 0);
    sweep(50);
    chk("rr0_hold", env(0), 256);
    key(0, 0, 1, 0);
    sweep(1);
    chk("koff_env0", env(0), 0);
    sweep(3);
    chk("koff_idle", env(0), 0);

    // ch2 full ADSR cycle
    key(1, 0, 0, 2);
    sweep(1);
    chk("atk_start", env(2), 0);
    sweep(511);
    chk("atk_255", env(2), 255);
    sweep(1);
    chk("atk_max", env(2), 256);
    sweep(167);
    chk("dec_201", env(2), 201);
    sweep(1);
    chk("dec_sl", env(2), 200);
    sweep(99);
    chk("sus_hold", env(2), 200);
    sweep(1);
    chk("sus_199", env(2), 199);
    key(0, 1, 0, 2);
    sweep(1);
    chk("rel_start", env(2), 199);
    sweep(4);
    chk("rel_198", env(2), 198);
    sweep(791);
    chk("rel_1", env(2), 1);
    sweep(1);
    chk("rel_0", env(2), 0);
    sweep(8);
    chk("rel_idle", env(2), 0);

    // ch1 legato re-attack keeps the current level
    key(1, 0, 0, 1);
    sweep(1);
    chk("leg_start", env(1), 0);
    sweep(100);
    chk("leg_100", env(1), 100);
    key(1, 0, 0, 1);
    sweep(1);
    chk("leg_rekey", env(1), 100);
    sweep(1);
    chk("leg_101", env(1), 101);
    sweep(1);
    chk("leg_102", env(1), 102);
    key(1, 0, 1, 1);
    sweep(1);
    chk("off_beats_on", env(1), 0);
    sweep(1);
    chk("on_discarded", env(1), 0);

    // ch3 key_on lands exactly on ch3's slot edge
    @(negedge clk) ifc.active_i = 1'b1;
    @(negedge clk) ifc.active_i = 1'b0;
    repeat (3) @(negedge clk);
    ifc.key_on_i[3] = 1'b1;
    @(negedge clk) ifc.key_on_i = '0;
    @(negedge clk);
    chk("coinc_start", env(3), 0);
    sweep(1);
    chk("coinc_1", env(3), 1);
    sweep(1);
    chk("coinc_2", env(3), 2);

    // active every 3 clk overruns the sweep; flag is sticky
    chk("ovr_pre", int'(ifc.overrun_o), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) ifc.active_i = 1'b1;
      @(negedge clk) ifc.active_i = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("ovr_set", int'(ifc.overrun_o), 1);
    sweep(3);
    chk("ovr_sticky", int'(ifc.overrun_o), 1);

    // reset in the middle of a sweep
    @(negedge clk) ifc.active_i = 1'b1;
    @(negedge clk) ifc.active_i = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("mid_rst_env3", env(3), 0);
    chk("mid_rst_env1", env(1), 0);
    chk("mid_rst_busy", int'(ifc.busy_o), 0);
    chk("mid_rst_ovr",  int'(ifc.overrun_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/wts_adsr_envelope_multi.md
Name: wts_adsr_envelope_multi

Overview:
- Parametrised, time-multiplexed ADSR envelope generator serving CH wave-table channels from one shared update datapath.
- Sits between the channel register file, which supplies the rates and key pulses, and the per-channel volume multipliers.
- Per-channel state, envelope and rate counter are stored in registers. Channels are updated one per clk during a sweep started by each 3.579MHz `active` pulse.
- Behaviour added over the single-channel generator:
  - channel count and widths are parameters;
  - key pulses are latched between slots;
  - legato re-attack;
  - overrun detection.

Parameters:
- CH, 5, number of channels (1..16); requires `active` period >= CH+1 clk.
- ENV_W, 9, envelope width; MAX = 2**(ENV_W-1) (256 at default).
- RATE_W, 16, width of AR/DR/SR/RR and of each per-channel tick counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- active  in  1  one-clk timing pulse at 3.579MHz; starts a sweep
- key_on  in  CH  per-channel one-clk pulse, bit k = channel k
- key_release  in  CH  per-channel one-clk pulse
- key_off  in  CH  per-channel one-clk pulse
- reg_ar  in  CH*RATE_W  attack rate, channel k at [k*RATE_W +: RATE_W]; same packing for reg_dr, reg_sr, reg_rr
- reg_dr  in  CH*RATE_W  decay rate
- reg_sr  in  CH*RATE_W  sustain rate
- reg_rr  in  CH*RATE_W  release rate
- reg_sl  in  CH*(ENV_W-1)  sustain level
- envelope  out  CH*ENV_W  registered envelopes, 0..MAX each
- busy  out  1  sweep in progress
- overrun  out  1  sticky: `active` arrived while busy

Behaviour:
- Reset (synchronous, at the clk edge where reset=1):
  - every channel: state IDLE, envelope 0, counter 0, pending bits 0;
  - busy=0, overrun=0, sweep index 0.
  - Reset mid-sweep aborts the sweep.
- Sweep:
  - Edge with active=1 and busy=0: busy<=1, idx<=0.
  - Following edges: channel idx is updated, then idx+1.
  - busy<=0 on the edge that updates channel CH-1.
  - Channel k therefore updates at edge A+1+k, where A is the edge sampling active.
  - active=1 while busy: ignored, overrun<=1.
- Key latching:
  - Each edge: pend_x[k] |= key_x[k].
  - At channel k's slot the effective event = pend_x[k] | key_x[k]; pend bits for k are then cleared. A pulse coinciding with the slot is consumed in that slot, never counted twice.
- Event priority within one slot: key_off > key_on > key_release. Only the winner acts; the others are discarded.
  - key_off: envelope 0, state IDLE, counter 0.
  - key_on, any state:
    - AR=0: envelope<=MAX, state DECAY;
    - else: state ATTACK, counter 0, envelope kept (legato re-attack from current level).
  - key_release: ignored in IDLE and RELEASE; otherwise state RELEASE, counter 0.
- Rate tick, no event, state with rate R≠0:
  - counter+1 >= R: counter<=0 and one envelope step;
  - else counter<=counter+1.
  - R=1 steps every slot.
- States:
  - IDLE: nothing changes.
  - ATTACK: step +1. Reaching MAX -> DECAY.
  - DECAY:
    - DR=0: envelope<=SL, go to SUSTAIN;
    - envelope <= SL on entry: go to SUSTAIN, no step;
    - else step -1; reaching SL -> SUSTAIN.
  - SUSTAIN:
    - SR=0: hold;
    - else step -1, saturating at 0. Stays SUSTAIN at 0.
  - RELEASE:
    - RR=0: hold indefinitely;
    - else step -1; reaching 0 -> IDLE.
- Arithmetic and widths:
  - Envelope never exceeds MAX and never goes below 0.
  - SL is zero-extended to ENV_W, so max SL = MAX-1.
  - Counter compare is unsigned RATE_W; counter wraps never (reset at R).
- Rates and SL are sampled at the slot; changing them mid-phase takes effect at the next slot.
- Envelope output changes only at that channel's slot edge. Latency from key pulse to envelope change is 1..(active period + CH) clk.

Test Plan (CH=4, ENV_W=9, RATE_W=16, active every 6 clk):
- Reset, 50 sweeps, no keys -> all envelopes 0, busy toggles, overrun 0.
- ch0 AR=0, key_on -> ch0=256 after its next slot; ch1..3 stay 0. Then key_release with RR=0 -> ch0 stays 256 for 50 sweeps. Then key_off -> ch0=0, IDLE.
- ch2 AR=2, DR=3, SL=200, SR=100, RR=4, key_on:
  - reaches 256 after 512 sweeps;
  - reaches 200 after 168 more;
  - 199 after 100 more.
  - key_release -> one step per 4 sweeps down to 0, then IDLE.
- Legato: ch1 AR=1 attack to 100, key_on again -> continues 101,102,… (no drop).
  - key_off + key_on in the same sweep -> env 0, IDLE; key_on discarded.
- key_on pulse on ch3 coinciding with ch3's slot edge -> exactly one attack start; no duplicate on the next slot.
- active period forced to 3 clk -> overrun=1 and stays 1 until reset; reset mid-sweep -> all outputs 0 next clk.
